// File: rtl/qft3_stream_ctrl.sv
// Stream controller for the 43-cycle QFT datapath: valid/ready intake, {valid,tag} token
// pipeline, credit-gated FWFT result FIFO. Define QFT_CTRL_PERF_EN to add perf counters.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

module qft3_stream_ctrl #(
  parameter int PIPE_LAT   = 43,
  parameter int FIFO_DEPTH = 48,
  parameter int TAG_W      = 4,
  parameter int INIT_CYC   = 2,
  parameter int DATA_W     = 16*`TOTAL_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [TAG_W-1:0]              s_tag,
  output logic                          dp_issue,
  input  logic [DATA_W-1:0]             dp_out,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W-1:0]             m_data,
  output logic [TAG_W-1:0]              m_tag,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic [$clog2(PIPE_LAT+1)-1:0] inflight
`ifdef QFT_CTRL_PERF_EN
  ,
  output logic [31:0]                   perf_accepted,
  output logic [31:0]                   perf_src_stall,
  output logic [31:0]                   perf_sink_stall
`endif
);
  localparam int IW  = $clog2(PIPE_LAT+1);
  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int SW  = ((IW > CW) ? IW : CW) + 1;
  localparam int ICW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam int EW  = TAG_W + DATA_W;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_e;

  state_e                         state_q, state_d;
  logic [ICW-1:0]                 init_cnt_q, init_cnt_d;
  logic                           flush_done_q, flush_done_d;
  logic [PIPE_LAT-1:0]            tok_vld_q, tok_vld_d;
  logic [PIPE_LAT-1:0][TAG_W-1:0] tok_tag_q, tok_tag_d;
  logic [IW-1:0]                  infl_q, infl_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]                  mem_q [FIFO_DEPTH];
  logic [EW-1:0]                  mem_d [FIFO_DEPTH];
  logic [SW-1:0]                  used;
  logic                           tok_exit, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Credit counts both in-flight tokens and parked results, so a landing token always has a slot.
  assign used       = SW'(infl_q) + SW'(cnt_q);
  assign s_ready    = (state_q == ST_RUN) && (used < SW'(FIFO_DEPTH));
  assign dp_issue   = s_valid & s_ready;
  assign tok_exit   = tok_vld_q[PIPE_LAT-1];
  assign m_valid    = (cnt_q != '0);
  assign pop        = m_valid & m_ready;
  assign {m_tag, m_data} = mem_q[rd_ptr_q];
  assign flush_done = flush_done_q;
  assign inflight   = infl_q;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_INIT:
        if (init_cnt_q == ICW'(INIT_CYC-1)) state_d = ST_RUN;
        else init_cnt_d = init_cnt_q + ICW'(1);
      ST_RUN:
        if (flush_req) state_d = ST_DRAIN;
      ST_DRAIN:
        if (infl_q == '0 && cnt_q == '0 && !flush_req) begin
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    tok_vld_d = {tok_vld_q[PIPE_LAT-2:0], dp_issue};
    tok_tag_d = {tok_tag_q[PIPE_LAT-2:0], s_tag};
    infl_d    = infl_q;
    if (dp_issue && !tok_exit)      infl_d = infl_q + IW'(1);
    else if (!dp_issue && tok_exit) infl_d = infl_q - IW'(1);
    cnt_d = cnt_q;
    if (tok_exit && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!tok_exit && pop) cnt_d = cnt_q - CW'(1);
    wr_ptr_d = tok_exit ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    // Full FIFO with a same-cycle pop: the write lands in the slot the head just vacated.
    mem_d = mem_q;
    if (tok_exit) mem_d[wr_ptr_q] = {tok_tag_q[PIPE_LAT-1], dp_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      flush_done_q <= 1'b0;
      tok_vld_q    <= '0;
      tok_tag_q    <= '0;
      infl_q       <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      flush_done_q <= flush_done_d;
      tok_vld_q    <= tok_vld_d;
      tok_tag_q    <= tok_tag_d;
      infl_q       <= infl_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_q        <= mem_d;
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CW'(FIFO_DEPTH));

`ifdef QFT_CTRL_PERF_EN
  logic [31:0] perf_acc_q, perf_acc_d, perf_src_q, perf_src_d, perf_snk_q, perf_snk_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    if (flush_done_d) begin
      perf_acc_d = '0;
      perf_src_d = '0;
      perf_snk_d = '0;
    end else begin
      perf_acc_d = sat_inc(perf_acc_q, dp_issue);
      perf_src_d = sat_inc(perf_src_q, s_valid && !s_ready && state_q == ST_RUN);
      perf_snk_d = sat_inc(perf_snk_q, m_valid && !m_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_acc_q <= '0;
      perf_src_q <= '0;
      perf_snk_q <= '0;
    end else begin
      perf_acc_q <= perf_acc_d;
      perf_src_q <= perf_src_d;
      perf_snk_q <= perf_snk_d;
    end
  end

  assign perf_accepted   = perf_acc_q;
  assign perf_src_stall  = perf_src_q;
  assign perf_sink_stall = perf_snk_q;
`endif

endmodule

// File: tb/tb_qft3_stream_ctrl.sv
// Bench for qft3_stream_ctrl: queue-based reference model of intake, in-flight tokens and
// result FIFO, plus a 43-stage stand-in datapath fed from the source bus.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif

module tb_qft3_stream_ctrl;
  localparam int PIPE_LAT   = 43;
  localparam int FIFO_DEPTH = 48;
  localparam int TAG_W      = 4;
  localparam int INIT_CYC   = 2;
  localparam int TW         = `TOTAL_WIDTH;
  localparam int DW         = 16*TW;
  localparam int IW         = $clog2(PIPE_LAT+1);

  logic             clk = 0, rst_n = 1, s_valid = 0, m_ready = 0, flush_req = 0;
  logic [TAG_W-1:0] s_tag = '0;
  logic [DW-1:0]    s_bus = '0;
  logic [DW-1:0]    dp_out, m_data;
  logic             s_ready, dp_issue, m_valid, flush_done;
  logic [TAG_W-1:0] m_tag;
  logic [IW-1:0]    inflight;
`ifdef QFT_CTRL_PERF_EN
  logic [31:0]      perf_accepted, perf_src_stall, perf_sink_stall;
`endif

  qft3_stream_ctrl #(.PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W),
                     .INIT_CYC(INIT_CYC), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_tag(s_tag),
    .dp_issue(dp_issue), .dp_out(dp_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_tag(m_tag), .flush_req(flush_req), .flush_done(flush_done),
    .inflight(inflight)
`ifdef QFT_CTRL_PERF_EN
    , .perf_accepted(perf_accepted), .perf_src_stall(perf_src_stall),
    .perf_sink_stall(perf_sink_stall)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in datapath: a basis |000> input of amplitude a spreads to round(a/sqrt(8)) on every
  // real part; anything else gets a fixed scramble so data alignment is still visible.
  function automatic logic [DW-1:0] dp_fn(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    int a;
    y = '0;
    if (x[DW-1:TW] == '0) begin
      a = (int'(x[TW-1:0]) * 181 + 256) >> 9;
      for (int k = 0; k < 8; k++) y[2*k*TW +: TW] = TW'(a);
    end else begin
      for (int i = 0; i < DW/32; i++) y[32*i +: 32] = x[32*i +: 32] ^ 32'hA5C3_0F96;
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] rnd_bus();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  logic [DW-1:0] dp_pipe [PIPE_LAT];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) dp_pipe[i] <= '0;
    end else begin
      dp_pipe[0] <= dp_fn(s_bus);
      for (int i = 1; i < PIPE_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
  assign dp_out = dp_pipe[PIPE_LAT-1];

  // Reference model: tokens carry their issue edge; they land in the result queue PIPE_LAT edges later.
  typedef struct { int t; logic [TAG_W-1:0] tag; logic [DW-1:0] data; } tok_t;
  typedef enum {P_INIT, P_RUN, P_DRAIN} phase_t;
  tok_t   inq[$];
  tok_t   fq[$];
  phase_t phase = P_INIT;
  int     e = 0;
  bit     done_exp = 0;
  int     checks = 0, failures = 0;
  int     n_iss = 0, n_pop = 0, n_done = 0, n_mv = 0, first_iss = -1, first_mv = -1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit   rdy, iss, pop, empty;
    tok_t tk;
    #1;
    rdy = (phase == P_RUN) && (inq.size() + fq.size() < FIFO_DEPTH);
    iss = s_valid && rdy;
    chk("s_ready", s_ready, rdy);
    chk("dp_issue", dp_issue, iss);
    chk("m_valid", m_valid, fq.size() > 0);
    chk("inflight", inflight, inq.size());
    chk("flush_done", flush_done, done_exp);
    if (fq.size() > 0) begin
      chk("m_tag", m_tag, fq[0].tag);
      chk("m_data", m_data, fq[0].data);
    end
    if (dp_issue) begin n_iss++; if (first_iss < 0) first_iss = e; end
    if (m_valid) begin n_mv++; if (first_mv < 0) first_mv = e; end
    if (m_valid && m_ready) n_pop++;
    if (flush_done) n_done++;
    pop   = (fq.size() > 0) && m_ready;
    empty = (inq.size() == 0) && (fq.size() == 0);
    @(posedge clk);
    done_exp = 0;
    if (pop) void'(fq.pop_front());
    if (inq.size() > 0 && inq[0].t + PIPE_LAT == e) fq.push_back(inq.pop_front());
    if (iss) begin
      tk.t = e; tk.tag = s_tag; tk.data = dp_fn(s_bus);
      inq.push_back(tk);
    end
    case (phase)
      P_INIT:  if (e >= INIT_CYC-1) phase = P_RUN;
      P_RUN:   if (flush_req) phase = P_DRAIN;
      default: if (empty && !flush_req) begin phase = P_RUN; done_exp = 1; end
    endcase
    e++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_flush_done", flush_done, 1'b0);
    chk("rst_dp_issue", dp_issue, 1'b0);
    chk("rst_inflight", inflight, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_tag", m_tag, 0);
    inq.delete(); fq.delete();
    phase = P_INIT; e = 0; done_exp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset/INIT and single |000> vector with tag 5, held at the consumer for inspection
    m_ready = 0; s_valid = 1; s_tag = 4'd5; s_bus = DW'(16);
    #3;
    do_reset();
    repeat (3) tick();
    s_valid = 0; s_tag = '0;
    for (int i = 0; i < 60 && first_mv < 0; i++) begin s_bus = rnd_bus(); tick(); end
    chk("first_issue_cycle", first_iss, 2);
    chk("single_latency", first_mv - first_iss, 44);
    chk("single_tag", m_tag, 4'd5);
    for (int k = 0; k < 8; k++) chk("single_re", m_data[2*k*TW +: TW], TW'(6));
    m_ready = 1;
    repeat (3) tick();
    chk("single_inflight_zero", inflight, 0);

    // Streaming: 100 back-to-back vectors, consumer always ready
    n_iss = 0; n_pop = 0;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1; s_tag = TAG_W'(i % 16); s_bus = rnd_bus(); tick();
    end
    chk("stream_issues", n_iss, 100);
    s_valid = 0;
    repeat (50) begin s_bus = rnd_bus(); tick(); end
    chk("stream_pops", n_pop, 100);

    // Backpressure: consumer stalled, source always valid
    m_ready = 0; n_iss = 0;
    for (int i = 0; i < 120; i++) begin
      s_valid = 1; s_tag = TAG_W'($urandom); s_bus = rnd_bus(); tick();
    end
    chk("bp_issues", n_iss, 48);
    chk("bp_ready_low", s_ready, 1'b0);
    s_valid = 0; m_ready = 1; n_pop = 0;
    repeat (60) tick();
    chk("bp_pops", n_pop, 48);
    chk("bp_empty", m_valid, 1'b0);

    // Flush with tokens in flight
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1; s_tag = TAG_W'($urandom); s_bus = rnd_bus(); tick();
    end
    flush_req = 1;
    tick();
    chk("flush_ready_drop", s_ready, 1'b0);
    s_valid = 0;
    repeat (60) tick();
    chk("flush_done_held", n_done, 0);
    flush_req = 0;
    repeat (3) tick();
    chk("flush_done_pulses", n_done, 1);
    chk("flush_resume_ready", s_ready, 1'b1);
    s_valid = 1; s_tag = 4'd9; s_bus = rnd_bus();
    tick();
    s_valid = 0;
    repeat (50) tick();

    // Mid-operation reset with 20 tokens in flight
    for (int i = 0; i < 20; i++) begin
      s_valid = 1; s_tag = TAG_W'($urandom); s_bus = rnd_bus(); tick();
    end
    chk("pre_reset_inflight", inflight, 20);
    s_valid = 0;
    do_reset();
    n_mv = 0;
    repeat (80) tick();
    chk("no_stale_after_reset", n_mv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qft3_stream_ctrl.md
# qft3_stream_ctrl

Stream controller for the 43-cycle pipelined 3-qubit QFT datapath, which has no stall input. The controller accepts state vectors over a valid/ready handshake and tracks each in-flight vector with a valid/tag token pipeline matched to the datapath latency. It captures datapath results into an output FIFO and uses credit-based admission so a stalled consumer never loses a result. It sits between the host-side state-vector source and the QFT datapath; the datapath input bus is driven straight from the source.

## Interface

**Parameters**
- PIPE_LAT, 43: datapath latency in cycles (six 7-cycle stages plus the 1-cycle swap).
- FIFO_DEPTH, 48: output FIFO entries. Must be at least PIPE_LAT+1 for full throughput.
- TAG_W, 4: width of the user tag carried alongside each vector.
- INIT_CYC, 2: cycles to wait after reset release, covering the datapath reset synchroniser.
- DATA_W, 16*`TOTAL_WIDTH: packed width of the 8 complex amplitudes, ordered f000_r in the LSBs up to f111_i in the MSBs.

**Ports**
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- s_valid, in, 1: source vector valid.
- s_ready, out, 1: controller accepts the vector.
- s_tag, in, TAG_W: tag of the source vector.
- dp_issue, out, 1: a vector enters the datapath this cycle (equals s_valid & s_ready).
- dp_out, in, DATA_W: packed datapath outputs.
- m_valid, out, 1: result available.
- m_ready, in, 1: consumer accepts the result.
- m_data, out, DATA_W: result amplitudes.
- m_tag, out, TAG_W: tag of the result.
- flush_req, in, 1: level request to drain the controller.
- flush_done, out, 1: one-cycle pulse when the drain completes.
- inflight, out, $clog2(PIPE_LAT+1): number of tokens currently in the pipeline.

## Operation

- **FSM states:** INIT, RUN, DRAIN.
  - INIT: after reset, count INIT_CYC cycles, then go to RUN.
  - RUN: go to DRAIN when flush_req=1.
  - DRAIN: go to RUN when inflight=0, the FIFO is empty and flush_req=0 is sampled. The transition cycle pulses flush_done.
- **Credit:** credit = FIFO_DEPTH − inflight − fifo_count.
  - s_ready = (state==RUN) & (credit>0), computed from registered state only. s_valid does not feed into s_ready.
- **Token pipeline:** a PIPE_LAT-deep shift register of {valid, tag}.
  - Stage 0 loads {dp_issue, s_tag}.
  - When the last stage is valid, {dp_out, tag} is written into the FIFO in that same cycle.
- **Counter updates:**
  - inflight: +1 on dp_issue, −1 on a token exiting. Both in one cycle leaves it unchanged.
  - fifo_count: +1 on a write, −1 on a pop (m_valid & m_ready). A simultaneous write and pop leaves it unchanged. A pop and a write are allowed in the same cycle even when the FIFO is full, because credit guarantees no overflow.
- **FIFO:** first-word-fall-through; m_data and m_tag come from the head entry.
  - When empty, m_valid=0 and m_data/m_tag hold their last value, which is don't-care.
- **Overflow check:** writing to a full FIFO is impossible by construction. Simulation asserts fifo_count ≤ FIFO_DEPTH.
- **Back-to-back input:** no bubbles are inserted. The datapath samples its input every cycle; on non-issue cycles the source bus content is garbage and carries no token.

## Timing

- **Reset values:** s_ready=0, m_valid=0, flush_done=0, dp_issue=0, inflight=0, m_data=0, m_tag=0, FSM=INIT, all token valids 0.
- **First acceptance:** s_ready can first be 1 in cycle INIT_CYC after rst_n deasserts (cycle 0 being the first rising edge with rst_n high).
- **Latency:** an issue at cycle t writes the FIFO at t+PIPE_LAT and asserts m_valid at t+PIPE_LAT+1. Minimum end-to-end latency is 44 cycles.
- **Throughput:** 1 vector/cycle sustained while m_ready=1 and FIFO_DEPTH ≥ PIPE_LAT+1.
- **Consumer stall:** when m_ready=0, s_ready falls in the cycle credit reaches 0. Tokens already in flight still land in the FIFO.
- **Reset mid-operation:** all tokens and FIFO contents are discarded immediately. The datapath is reset by the same rst_n.
- **flush_req:** takes effect on the next edge, where s_ready drops. flush_req asserted during INIT is honoured once INIT completes.

## Configuration

- **QFT_CTRL_PERF_EN defined:** adds 32-bit saturating counters plus their output ports:
  - perf_accepted, out, 32: number of dp_issue cycles.
  - perf_src_stall, out, 32: cycles with s_valid & !s_ready in RUN.
  - perf_sink_stall, out, 32: cycles with m_valid & !m_ready.
  - All three reset to 0 and are cleared on flush_done.
- **Undefined:** the counters and their ports are absent; behaviour is otherwise identical.

## Test plan

- **Reset/INIT:** release rst_n, hold s_valid=1 → s_ready=0 for cycles 0–1, s_ready=1 at cycle 2, first issue at cycle 2.
- **Single vector:** issue tag 5 with |000⟩ (i000_r=16, rest 0) → at issue+44 m_valid=1, m_tag=5, and all eight real parts equal the datapath's fixed-point 1/√8 result; inflight returns to 0.
- **Streaming:** 100 back-to-back vectors with tags 0..15 repeating, m_ready=1 → no s_ready drop, results in order, one per cycle from cycle 44 onward.
- **Backpressure:** m_ready=0, continuous s_valid → exactly 48 issues then s_ready=0. Release m_ready → all 48 results popped in order with no loss and no duplicates.
- **Flush:** assert flush_req with 10 tokens in flight → s_ready=0 next cycle; flush_done pulses once after the last pop and the deassertion of flush_req; then RUN resumes.
- **Mid-operation reset:** assert rst_n=0 with 20 in flight → outputs return to their reset values immediately, and no stale result appears after re-INIT.
